// File: rtl/present_key_fun.sv
// PRESENT-80 key schedule, one round per clock; latency 1 cycle, no backpressure (loads on every edge).
// Define PRESENT_ROUND_KEY_OUT_EN to add outRoundKey, which mirrors outData[79:16].
module present_key_fun (
    input  logic        inClk,
    input  logic        inRst,
    input  logic [79:0] inData,
    input  logic [4:0]  inRoundCounter,
    output logic [79:0] outData
`ifdef PRESENT_ROUND_KEY_OUT_EN
    ,
    output logic [63:0] outRoundKey
`endif
);

    logic [79:0] r_key;
    logic [79:0] w_rot;
    logic [3:0]  w_sbox;
    logic [79:0] w_next;

    assign w_rot = {inData[18:0], inData[79:19]};

    always_comb begin
        w_sbox = 4'h0;
        case (w_rot[79:76])
            4'h0: w_sbox = 4'hC;
            4'h1: w_sbox = 4'h5;
            4'h2: w_sbox = 4'h6;
            4'h3: w_sbox = 4'hB;
            4'h4: w_sbox = 4'h9;
            4'h5: w_sbox = 4'h0;
            4'h6: w_sbox = 4'hA;
            4'h7: w_sbox = 4'hD;
            4'h8: w_sbox = 4'h3;
            4'h9: w_sbox = 4'hE;
            4'hA: w_sbox = 4'hF;
            4'hB: w_sbox = 4'h8;
            4'hC: w_sbox = 4'h4;
            4'hD: w_sbox = 4'h7;
            4'hE: w_sbox = 4'h1;
            4'hF: w_sbox = 4'h2;
            default: w_sbox = 4'hx;
        endcase
    end

    // Counter lands on exactly bits 19:15 of the rotated key.
    always_comb begin
        w_next        = w_rot;
        w_next[79:76] = w_sbox;
        w_next[19:15] = w_rot[19:15] ^ inRoundCounter;
    end

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            r_key <= 80'h0;
        end else begin
            r_key <= w_next;
        end
    end

    assign outData = r_key;

`ifdef PRESENT_ROUND_KEY_OUT_EN
    assign outRoundKey = r_key[79:16];
`endif

endmodule

// File: tb/tb_present_key_fun.sv
// Self-checking bench for present_key_fun against a plain-arithmetic model of the key update.
module tb_present_key_fun;

    logic        inClk;
    logic        inRst;
    logic [79:0] inData;
    logic [4:0]  inRoundCounter;
    logic [79:0] outData;
`ifdef PRESENT_ROUND_KEY_OUT_EN
    logic [63:0] outRoundKey;
`endif

    int n_cmp;
    int n_bad;

    logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_key_fun dut (
        .inClk          (inClk),
        .inRst          (inRst),
        .inData         (inData),
        .inRoundCounter (inRoundCounter),
        .outData        (outData)
`ifdef PRESENT_ROUND_KEY_OUT_EN
        ,
        .outRoundKey    (outRoundKey)
`endif
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    function automatic logic [79:0] ref_f(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        logic [79:0] x;
        t = (k << 61) | (k >> 19);
        t[79:76] = SBOX[t[79:76]];
        x = {75'b0, rc};
        t = t ^ (x << 15);
        return t;
    endfunction

    function automatic logic [79:0] rand80();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    task automatic check_out(input string name, input logic [79:0] exp);
        n_cmp++;
        if (outData !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, outData, exp);
        end
`ifdef PRESENT_ROUND_KEY_OUT_EN
        n_cmp++;
        if (outRoundKey !== exp[79:16]) begin
            n_bad++;
            $display("FAIL %s roundkey: got %h expected %h", name, outRoundKey, exp[79:16]);
        end
`endif
    endtask

    task automatic clock_in(input logic [79:0] k, input logic [4:0] rc);
        inData = k;
        inRoundCounter = rc;
        @(posedge inClk);
        #1;
    endtask

    task automatic test_reset();
        inData = '1;
        inRoundCounter = 5'd31;
        inRst = 1'b0;
        #1;
        inRst = 1'b1;
        #1;
        check_out("reset_async", 80'h0);
        @(posedge inClk);
        #2;
        check_out("reset_held_edge", 80'h0);
        inRst = 1'b0;
    endtask

    task automatic test_rounds();
        clock_in(80'h0, 5'd1);
        check_out("round1", 80'hC0000000000000008000);
        clock_in(80'hC0000000000000008000, 5'd2);
        check_out("round2", 80'h50001800000000010000);
        clock_in(80'h50001800000000010000, 5'd3);
        check_out("round3", 80'h60000A00030000018000);
    endtask

    task automatic test_sbox();
        logic [79:0] k;
        logic [79:0] e;
        for (int v = 0; v < 16; v++) begin
            k = 80'h0;
            k[18:15] = v[3:0];
            e = 80'h0;
            e[79:76] = SBOX[v];
            clock_in(k, 5'd0);
            check_out($sformatf("sbox_%0h", v), e);
        end
    endtask

    task automatic test_counter_boundary();
        clock_in(80'h0, 5'd31);
        check_out("rc31", 80'hC00000000000000F8000);
        clock_in(80'h0, 5'd0);
        check_out("rc0", 80'hC0000000000000000000);
    endtask

    task automatic test_back_to_back();
        logic [79:0] k;
        logic [4:0]  rc;
        for (int i = 0; i < 60; i++) begin
            k  = rand80();
            rc = 5'($urandom_range(0, 31));
            clock_in(k, rc);
            check_out($sformatf("rand_%0d", i), ref_f(k, rc));
        end
    endtask

    task automatic test_mid_reset();
        logic [79:0] k;
        k = 80'h0;
        for (int r = 1; r <= 3; r++) begin
            clock_in(k, 5'(r));
            k = ref_f(k, 5'(r));
        end
        check_out("chain_pre_reset", k);
        inData = k;
        inRoundCounter = 5'd4;
        #2;
        inRst = 1'b1;
        #1;
        check_out("mid_reset_clear", 80'h0);
        @(posedge inClk);
        #1;
        check_out("mid_reset_hold", 80'h0);
        inRst = 1'b0;
        k = 80'h0;
        for (int r = 1; r <= 5; r++) begin
            clock_in(k, 5'(r));
            k = ref_f(k, 5'(r));
            check_out($sformatf("resume_r%0d", r), k);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        inRst = 1'b0;
        inData = '0;
        inRoundCounter = '0;
        test_reset();
        test_rounds();
        test_sbox();
        test_counter_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
